// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmit peripheral: byte FIFO plus a serializer with a programmable bit period.
// Define UART_TX_PARITY_EN to add an even parity bit after the data bits (11-bit frame).
module uart_tx_periph #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [3:0]  addr_i,
    input  logic [3:0]  we_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [7:0]  r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [PW:0] r_cnt;
    logic        r_ovf;
    logic [15:0] r_baudDiv;
    logic        r_irqEn;
    logic [31:0] r_dataOut;
    logic        r_irq;

    state_t      r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_bitIdx;
    logic [15:0] r_baudCnt;
    logic        r_tx;
`ifdef UART_TX_PARITY_EN
    logic        r_parity;
`endif

    logic        w_write;
    logic        w_read;
    logic        w_pushReq;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_busy;
    logic        w_bitEnd;
    logic [7:0]  w_head;
    logic [31:0] w_status;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_write   = en_i && (we_i != 4'b0000);
    assign w_read    = en_i && (we_i == 4'b0000);
    assign w_pushReq = w_write && (addr_i == 4'h0);
    assign w_full    = (r_cnt == DEPTH_CNT);
    assign w_empty   = (r_cnt == '0);
    assign w_busy    = (r_state != S_IDLE);
    assign w_bitEnd  = (r_baudCnt == 16'd0);
    assign w_head    = r_fifo[r_rdPtr];
    // The serializer takes a byte when idle or exactly as a stop bit finishes, so frames chain without a gap.
    assign w_pop     = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bitEnd));
    assign w_push    = w_pushReq && (!w_full || w_pop);
    assign w_status  = 32'({r_cnt, 3'b000, r_ovf, w_full, w_empty, w_busy, 1'b0});
    assign w_unused  = ^data_i[31:16];

    always_comb begin
        w_rdata = 32'd0;
        case (addr_i)
            4'h4:    w_rdata = w_status;
            4'h8:    w_rdata = {16'd0, r_baudDiv};
            4'hC:    w_rdata = {31'd0, r_irqEn};
            default: w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wrPtr] <= data_i[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_baudDiv <= 16'(DEFAULT_DIV);
            r_irqEn   <= 1'b0;
            r_dataOut <= 32'd0;
            r_irq     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_pushReq && !w_push) begin
                r_ovf <= 1'b1;
            end else if (w_read && (addr_i == 4'h4)) begin
                r_ovf <= 1'b0;
            end
            if (w_write && (addr_i == 4'h8)) begin
                r_baudDiv <= data_i[15:0];
            end
            if (w_write && (addr_i == 4'hC)) begin
                r_irqEn <= data_i[0];
            end
            r_dataOut <= w_read ? w_rdata : 32'd0;
            r_irq     <= r_irqEn & w_empty & ~w_busy;
        end
    end

    // Every bit boundary reloads the divider, so a BAUDDIV change applies from the next bit onward.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_shift   <= 8'd0;
            r_bitIdx  <= 3'd0;
            r_baudCnt <= 16'd0;
            r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift   <= w_head;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= ^w_head;
`endif
                        r_baudCnt <= r_baudDiv;
                        r_tx      <= 1'b0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (w_bitEnd) begin
                        r_baudCnt <= r_baudDiv;
                        r_bitIdx  <= 3'd0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_baudCnt <= r_baudCnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bitEnd) begin
                        r_baudCnt <= r_baudDiv;
                        if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                            r_shift  <= r_shift >> 1;
                            r_tx     <= r_shift[1];
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt - 16'd1;
                    end
                end
                S_PARITY: begin
                    if (w_bitEnd) begin
                        r_baudCnt <= r_baudDiv;
                        r_tx      <= 1'b1;
                        r_state   <= S_STOP;
                    end else begin
                        r_baudCnt <= r_baudCnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bitEnd) begin
                        if (w_pop) begin
                            r_shift   <= w_head;
`ifdef UART_TX_PARITY_EN
                            r_parity  <= ^w_head;
`endif
                            r_baudCnt <= r_baudDiv;
                            r_tx      <= 1'b0;
                            r_state   <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt - 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_o = r_dataOut;
    assign tx_o   = r_tx;
    assign irq_o  = r_irq;

endmodule
